// File: rtl/slot_capture_ctrl_if.sv
// Slot capture bus: control, sampled-slot input and FIFO output handshake.
// master drives requests and consumes data; slave is the controller.
interface slot_capture_ctrl_if #(
   parameter int width = 10
);
   logic             cen;
   logic             start;
   logic [3:0]       frames;
   logic [23:0]      mask;
   logic [width-1:0] mixed;
   logic [4:0]       cnt;
   logic             sync;
   logic             busy;
   logic             done;
   logic [width-1:0] dout;
   logic [4:0]       dslot;
   logic             dvalid;
   logic             dready;
   logic             overflow;

   modport master (
      output cen, start, frames, mask, mixed, dready,
      input  cnt, sync, busy, done, dout, dslot, dvalid, overflow
   );

   modport slave (
      input  cen, start, frames, mask, mixed, dready,
      output cnt, sync, busy, done, dout, dslot, dvalid, overflow
   );
endinterface

// File: rtl/slot_capture_ctrl.sv
// Captures selected slots of a 24-slot TDM stream over N frames
// into a small FIFO with a valid/ready consumer side.
module slot_capture_ctrl #(
   parameter int         width = 10,
   parameter logic [4:0] pos0  = 5'd0,
   parameter int         depth = 4
) (
   input logic clk,
   input logic rst_n,
   slot_capture_ctrl_if.slave bus
);
   localparam int AW = $clog2(depth);
   localparam logic [AW:0] FULL = (AW+1)'(depth);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CAP,
      S_DRAIN
   } state_t;

   state_t           state_q;
   logic [4:0]       cnt_q, cnt_d;
   logic [5:0]       sum;
   logic [4:0]       slot;
   logic             sync;
   logic [3:0]       frames_q, rem_q;
   logic [23:0]      mask_q;
   logic             done_q, ovf_q;
   logic [width-1:0] data_mem [depth];
   logic [4:0]       slot_mem [depth];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      count_q, count_d;
   logic             empty, full;
   logic             push_req, push, pop;

   always_comb begin
      sum = {1'b0, cnt_q} + {1'b0, pos0};
      if (sum >= 6'd48) begin
         slot = 5'(sum - 6'd48);
      end else if (sum >= 6'd24) begin
         slot = 5'(sum - 6'd24);
      end else begin
         slot = sum[4:0];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.cen) begin
         cnt_d = (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
      end
   end

   assign sync     = bus.cen && (slot == 5'd23);
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL);
   assign pop      = !empty && bus.dready;
   assign push_req = (state_q == S_CAP) && bus.cen && mask_q[slot];
   // A full FIFO still takes the sample when the head leaves this cycle
   assign push     = push_req && (!full || pop);
   assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_q] <= bus.mixed;
         slot_mem[wr_q] <= slot;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         frames_q <= '0;
         rem_q    <= '0;
         mask_q   <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         count_q <= count_d;
         done_q  <= 1'b0;
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         if (push_req && full && !pop) ovf_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  ovf_q <= 1'b0;
                  if (bus.frames != 4'd0) begin
                     frames_q <= bus.frames;
                     mask_q   <= bus.mask;
                     state_q  <= S_WAIT;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (sync) begin
                  rem_q   <= frames_q;
                  state_q <= S_CAP;
               end
            end
            S_CAP: begin
               if (sync) begin
                  rem_q <= rem_q - 4'd1;
                  if (rem_q == 4'd1) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cnt      = cnt_q;
   assign bus.sync     = sync;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;
   assign bus.dvalid   = !empty;
   assign bus.dout     = empty ? '0 : data_mem[rd_q];
   assign bus.dslot    = empty ? '0 : slot_mem[rd_q];
   assign bus.overflow = ovf_q;
endmodule
